insn_encoder: RTL
=================

INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 SHALL have parameter INSN_WIDTH, default 32, width of an emitted instruction word; only 32 is supported.
REQ-002 SHALL have parameter DEPTH, default 4, number of output FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  field bundle valid.
REQ-006 in_ready  output  1  encoder can accept a bundle.
REQ-007 fmt  input  3  format: 0 OP-V ALU, 1 vsetvli, 2 vsetivli, 3 vsetvl, 4 vector load, 5 vector store, 6-7 illegal.
REQ-008 dest, src_1, src_2  input  5 each  vd/rd/vs3, vs1/rs1/imm/uimm, vs2/rs2/lumop/sumop.
REQ-009 opcode_mnr  input  3  funct3 for ALU formats.
REQ-010 width  input  3  memory element width.
REQ-011 mop  input  2  memory addressing mode.
REQ-012 mew  input  1  memory extended-width bit.
REQ-013 nf  input  3  memory segment field count.
REQ-014 vm  input  1  mask bit.
REQ-015 funct6  input  6  ALU function.
REQ-016 zimm_11  input  11  vsetvli vtype immediate.
REQ-017 zimm_10  input  10  vsetivli vtype immediate.
REQ-018 insn_out  output  32  encoded instruction at FIFO head.
REQ-019 out_valid  output  1  insn_out is valid.
REQ-020 out_ready  input  1  consumer accepts insn_out.
REQ-021 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-022 err  output  1  one-cycle pulse when an illegal bundle is dropped.

Function
REQ-023 SHALL accept a bundle on a clock edge where in_valid and in_ready are both 1; in_ready SHALL equal (count < DEPTH) and SHALL NOT depend on out_ready.
REQ-024 For fmt 0, SHALL encode funct6[31:26], vm[25], src_2[24:20], src_1[19:15], opcode_mnr[14:12], dest[11:7], and 7'b1010111[6:0].
REQ-025 For fmt 1, SHALL encode 0[31], zimm_11[30:20], src_1[19:15], 3'b111, dest, and 7'b1010111.
REQ-026 For fmt 2, SHALL encode 2'b11[31:30], zimm_10[29:20], src_1[19:15], 3'b111, dest, and 7'b1010111.
REQ-027 For fmt 3, SHALL encode 7'b1000000[31:25], src_2, src_1, 3'b111, dest, and 7'b1010111.
REQ-028 For fmt 4, SHALL encode nf[31:29], mew[28], mop[27:26], vm[25], src_2, src_1, width[14:12], dest, and 7'b0000111.
REQ-029 For fmt 5, SHALL use the fmt 4 encoding with opcode 7'b0100111.
REQ-030 SHALL treat fmt 6/7, and fmt 0 with opcode_mnr = 3'b111, as illegal: the bundle is consumed, not enqueued, and err pulses high for exactly the following cycle.
REQ-031 Latency: a legal bundle accepted at edge N into an empty FIFO SHALL appear on insn_out with out_valid = 1 after edge N.
REQ-032 out_valid SHALL equal (count != 0); insn_out SHALL be the oldest entry; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-033 When a push and a pop occur on the same edge, count SHALL be unchanged and order SHALL be preserved; this includes the full case only when the push was accepted (count < DEPTH).
REQ-034 Read and write pointers SHALL wrap modulo DEPTH.
REQ-035 insn_out SHALL be stable while out_valid = 1 and out_ready = 0.

Reset
REQ-036 While rst = 0: count = 0, out_valid = 0, err = 0, insn_out = 0, pointers = 0, and in_ready = 1 after release.
REQ-037 Reset asserted mid-operation SHALL discard all queued entries immediately and asynchronously.

Verification
REQ-038 Bench SHALL apply fmt 0, funct6 = 000000, vm = 1, src_2 = 2, src_1 = 1, opcode_mnr = 000, dest = 3, out_ready = 1 -> insn_out = 0x022081D7 one cycle later.
REQ-039 Bench SHALL apply fmt 1, zimm_11 = 0x0D0, src_1 = 10, dest = 5 -> insn_out = 0x0D0572D7.
REQ-040 Bench SHALL hold out_ready = 0 and push 5 legal bundles -> first 4 accepted, in_ready = 0 and count = 4 on the 5th; then release out_ready -> 4 words emerge in order.
REQ-041 Bench SHALL apply fmt 7, then fmt 0 with opcode_mnr = 111 -> err pulses once per bundle, count stays 0, out_valid stays 0.
REQ-042 Bench SHALL perform a simultaneous push and pop at count = 2 -> count stays 2 and order is preserved across pointer wrap after 10 such cycles.
REQ-043 Bench SHALL fill to 3 entries, then pulse rst low mid-cycle -> out_valid = 0 and count = 0 immediately, and no stale word appears after release.

Source files
------------

// File: rtl/insn_encoder.sv
// RVV instruction encoder: packs a decoded field bundle into a 32-bit instruction
// word and queues it in a small FIFO; illegal bundles are dropped with an err pulse.
module insn_encoder #(
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               fmt,
  input  logic [4:0]               dest,
  input  logic [4:0]               src_1,
  input  logic [4:0]               src_2,
  input  logic [2:0]               opcode_mnr,
  input  logic [2:0]               width,
  input  logic [1:0]               mop,
  input  logic                     mew,
  input  logic [2:0]               nf,
  input  logic                     vm,
  input  logic [5:0]               funct6,
  input  logic [10:0]              zimm_11,
  input  logic [9:0]               zimm_10,
  output logic [INSN_WIDTH-1:0]    insn_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [6:0] OP_V  = 7'b1010111;
  localparam logic [6:0] OP_LD = 7'b0000111;
  localparam logic [6:0] OP_ST = 7'b0100111;

  typedef struct packed {
    logic                  legal;
    logic [INSN_WIDTH-1:0] word;
  } enc_t;

  enc_t enc;
  logic [INSN_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic accept, push, pop;

  always_comb begin
    enc.legal = 1'b1;
    enc.word  = '0;
    case (fmt)
      3'd0: begin
        enc.word  = {funct6, vm, src_2, src_1, opcode_mnr, dest, OP_V};
        enc.legal = (opcode_mnr != 3'b111);  // funct3=111 belongs to vset*
      end
      3'd1: enc.word = {1'b0, zimm_11, src_1, 3'b111, dest, OP_V};
      3'd2: enc.word = {2'b11, zimm_10, src_1, 3'b111, dest, OP_V};
      3'd3: enc.word = {7'b1000000, src_2, src_1, 3'b111, dest, OP_V};
      3'd4: enc.word = {nf, mew, mop, vm, src_2, src_1, width, dest, OP_LD};
      3'd5: enc.word = {nf, mew, mop, vm, src_2, src_1, width, dest, OP_ST};
      default: enc.legal = 1'b0;
    endcase
  end

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc.legal;
  assign pop       = out_valid && out_ready;
  assign insn_out  = out_valid ? mem[rptr] : '0;

  // Storage needs no reset: entries are only visible through count/out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= enc.word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      err <= accept && !enc.legal;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
